// File: rtl/sobel_gradient_if.sv
// FIFO-side handshake bundle for the Sobel stage: upstream pop port and downstream push port.
interface sobel_gradient_if;
    logic       in_rd_en;
    logic       in_empty;
    logic [7:0] in_dout;
    logic       out_wr_en;
    logic       out_full;
    logic [7:0] out_din;

    modport master (
        output in_rd_en,
        input  in_empty,
        input  in_dout,
        output out_wr_en,
        input  out_full,
        output out_din
    );

    modport slave (
        input  in_rd_en,
        output in_empty,
        output in_dout,
        input  out_wr_en,
        output out_full,
        input  out_din
    );
endinterface

// File: rtl/sobel_gradient.sv
// Streaming 3x3 Sobel gradient magnitude over a line-buffer shift register,
// one output per two cycles, borders forced to zero.
module sobel_gradient #(
    parameter int unsigned WIDTH  = 1280,
    parameter int unsigned HEIGHT = 720
) (
    input  logic             clock,
    input  logic             reset,
    sobel_gradient_if.master bus
);
    localparam int unsigned DEPTH       = 2 * WIDTH + 3;
    localparam int unsigned CW          = $clog2(WIDTH);
    localparam int unsigned RW          = $clog2(HEIGHT + 1);
    localparam int unsigned PW          = $clog2(WIDTH + 3);
    localparam int unsigned FLUSH_START = WIDTH * HEIGHT - 1 - (WIDTH + 2);

    typedef enum logic [1:0] {PROLOGUE, COMPUTE, WRITE} state_e;

    state_e          state_q, state_d;
    logic [7:0]      sr_q [DEPTH];
    logic [7:0]      sr_d [DEPTH];
    logic [PW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [7:0]      result_q, result_d;

    logic            rd_en, wr_en, shift, in_flush, border;
    logic [7:0]      shift_pix, result_c;
    logic [31:0]     pix_idx;
    logic signed [10:0] p00, p01, p02, p10, p12, p20, p21, p22, gx, gy;
    logic [10:0]     ax, ay;
    logic [11:0]     mag_sum, mag;

    always_comb begin
        p00 = 11'(sr_q[0]);
        p01 = 11'(sr_q[1]);
        p02 = 11'(sr_q[2]);
        p10 = 11'(sr_q[WIDTH]);
        p12 = 11'(sr_q[WIDTH + 2]);
        p20 = 11'(sr_q[2 * WIDTH]);
        p21 = 11'(sr_q[2 * WIDTH + 1]);
        p22 = 11'(sr_q[2 * WIDTH + 2]);
        gx = (p02 + (p12 <<< 1) + p22) - (p00 + (p10 <<< 1) + p20);
        gy = (p20 + (p21 <<< 1) + p22) - (p00 + (p01 <<< 1) + p02);
        ax = gx[10] ? 11'(-gx) : 11'(gx);
        ay = gy[10] ? 11'(-gy) : 11'(gy);
        mag_sum = {1'b0, ax} + {1'b0, ay};
        mag = mag_sum >> 1;
        border = (row_q == '0) || (row_q == RW'(HEIGHT - 1)) ||
                 (col_q == '0) || (col_q == CW'(WIDTH - 1));
        if (border) begin
            result_c = '0;
        end else if (mag > 12'd255) begin
            result_c = 8'hFF;
        end else begin
            result_c = mag[7:0];
        end
    end

    // Once the centre is within WIDTH+2 of the frame end, every missing pixel is a zero
    // flush; real input is never borrowed from the following frame.
    always_comb begin
        pix_idx  = 32'(row_q) * WIDTH + 32'(col_q);
        in_flush = pix_idx > FLUSH_START;
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        col_d     = col_q;
        row_d     = row_q;
        result_d  = result_q;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        shift     = 1'b0;
        shift_pix = '0;
        case (state_q)
            PROLOGUE: begin
                if (!bus.in_empty) begin
                    rd_en     = 1'b1;
                    shift     = 1'b1;
                    shift_pix = bus.in_dout;
                    cnt_d     = cnt_q + PW'(1);
                    if (cnt_q == PW'(WIDTH + 1)) state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                if (in_flush) begin
                    shift = 1'b1;
                end else if (!bus.in_empty) begin
                    rd_en     = 1'b1;
                    shift     = 1'b1;
                    shift_pix = bus.in_dout;
                end
                if (shift) begin
                    result_d = result_c;
                    state_d  = WRITE;
                    if (col_q == CW'(WIDTH - 1)) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            WRITE: begin
                if (!bus.out_full) begin
                    wr_en = 1'b1;
                    // row reaching HEIGHT marks the write of the final pixel of the frame
                    if (row_q == RW'(HEIGHT)) begin
                        state_d = PROLOGUE;
                        row_d   = '0;
                        col_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = COMPUTE;
                    end
                end
            end
            default: state_d = PROLOGUE;
        endcase
        if (shift) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) sr_d[i] = sr_q[i + 1];
            sr_d[DEPTH - 1] = shift_pix;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= PROLOGUE;
            for (int unsigned i = 0; i < DEPTH; i++) sr_q[i] <= '0;
            cnt_q    <= '0;
            col_q    <= '0;
            row_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            col_q    <= col_d;
            row_q    <= row_d;
            result_q <= result_d;
        end
    end

    assign bus.in_rd_en  = rd_en && reset;
    assign bus.out_wr_en = wr_en && reset;
    assign bus.out_din   = result_q;
endmodule
